// File: rtl/pipe_stage_chain_if.sv
// Bundle of the pipe_stage_chain signals: upstream stimulus, stall/flush control and last-stage outputs.
// With PIPE_CHAIN_BYPASS_EN defined it also carries the forwarding query (qry_rd) and result (fwd_hit, fwd_data).
interface pipe_stage_chain_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              stall;
    logic              flush;
    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [ADDR_W-1:0] rd_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [ADDR_W-1:0] rd_out;
    logic [DATA_W-1:0] data_out;
    logic [OCC_W-1:0]  occupancy;
`ifdef PIPE_CHAIN_BYPASS_EN
    logic [ADDR_W-1:0] qry_rd;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output stall, flush, valid_in, ctrl_in, rd_in, data_in, qry_rd,
        input  valid_out, ctrl_out, rd_out, data_out, occupancy, fwd_hit, fwd_data
    );
    modport slave (
        input  stall, flush, valid_in, ctrl_in, rd_in, data_in, qry_rd,
        output valid_out, ctrl_out, rd_out, data_out, occupancy, fwd_hit, fwd_data
    );
`else
    modport master (
        output stall, flush, valid_in, ctrl_in, rd_in, data_in,
        input  valid_out, ctrl_out, rd_out, data_out, occupancy
    );
    modport slave (
        input  stall, flush, valid_in, ctrl_in, rd_in, data_in,
        output valid_out, ctrl_out, rd_out, data_out, occupancy
    );
`endif
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline register chain with stall, flush, bubble gating and occupancy count.
// Optional PIPE_CHAIN_BYPASS_EN adds a combinational forwarding lookup across all stages.
module pipe_stage_chain #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1
) (
    input logic               clk,
    input logic               reset,
    pipe_stage_chain_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              stage_valid [DEPTH];
    logic [CTRL_W-1:0] stage_ctrl  [DEPTH];
    logic [ADDR_W-1:0] stage_rd    [DEPTH];
    logic [DATA_W-1:0] stage_data  [DEPTH];

    logic [OCC_W-1:0]  occ_reg;
    logic [OCC_W-1:0]  occ_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic              valid_reg;
            logic [CTRL_W-1:0] ctrl_reg;
            logic [ADDR_W-1:0] rd_reg;
            logic [DATA_W-1:0] data_reg;
            logic              valid_next;
            logic [CTRL_W-1:0] ctrl_next;
            logic [ADDR_W-1:0] rd_next;
            logic [DATA_W-1:0] data_next;

            if (gi == 0) begin : g_head
                // Bubbles entering the chain are scrubbed so they never carry a stray regWrite.
                assign valid_next = bus.valid_in;
                assign ctrl_next  = bus.valid_in ? bus.ctrl_in : '0;
                assign rd_next    = bus.valid_in ? bus.rd_in : '1;
                assign data_next  = bus.data_in;
            end else begin : g_body
                assign valid_next = stage_valid[gi-1];
                assign ctrl_next  = stage_ctrl[gi-1];
                assign rd_next    = stage_rd[gi-1];
                assign data_next  = stage_data[gi-1];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    ctrl_reg  <= '0;
                    rd_reg    <= '1;
                    data_reg  <= '0;
                end else if (bus.flush) begin
                    valid_reg <= 1'b0;
                    ctrl_reg  <= '0;
                    rd_reg    <= '1;
                end else if (!bus.stall) begin
                    valid_reg <= valid_next;
                    ctrl_reg  <= ctrl_next;
                    rd_reg    <= rd_next;
                    data_reg  <= data_next;
                end
            end

            assign stage_valid[gi] = valid_reg;
            assign stage_ctrl[gi]  = ctrl_reg;
            assign stage_rd[gi]    = rd_reg;
            assign stage_data[gi]  = data_reg;
        end
    endgenerate

    // Net change is +1, -1 or 0 depending on whether a valid enters and/or leaves on this edge.
    always_comb begin
        occ_next = occ_reg;
        if (bus.valid_in && !stage_valid[DEPTH-1]) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (!bus.valid_in && stage_valid[DEPTH-1]) begin
            occ_next = occ_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            occ_reg <= '0;
        end else if (!bus.stall) begin
            occ_reg <= occ_next;
        end
    end

    assign bus.valid_out = stage_valid[DEPTH-1];
    assign bus.ctrl_out  = stage_ctrl[DEPTH-1];
    assign bus.rd_out    = stage_rd[DEPTH-1];
    assign bus.data_out  = stage_data[DEPTH-1];
    assign bus.occupancy = occ_reg;

`ifdef PIPE_CHAIN_BYPASS_EN
    logic              fwd_hit_next;
    logic [DATA_W-1:0] fwd_data_next;

    // Scan oldest to youngest so the lowest-index (youngest) match wins.
    always_comb begin
        fwd_hit_next  = 1'b0;
        fwd_data_next = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (stage_valid[i] && stage_ctrl[i][0] && (stage_rd[i] == bus.qry_rd)
                    && (bus.qry_rd != '1)) begin
                fwd_hit_next  = 1'b1;
                fwd_data_next = stage_data[i];
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit_next;
    assign bus.fwd_data = fwd_data_next;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (DEPTH=3): accepted transactions are queued with their
// advance count, and a negedge monitor checks outputs, occupancy and (optionally) forwarding.
module tb_pipe_stage_chain;
    localparam int DATA_W = 64;
    localparam int CTRL_W = 4;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        int                adv;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_chain_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    pipe_stage_chain #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ent_t exp_q[$];
    ent_t pend;
    bit   pend_ok = 1'b0;
    bit   mon_en = 1'b0;
    bit   prev_reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock of stimulus; the previous cycle's accepted input is queued once its capture edge has passed.
    task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [ADDR_W-1:0] r,
                         input logic [DATA_W-1:0] d, input bit st, input bit fl, input bit rs,
                         input int q);
        @(posedge clk);
        #1;
        if (pend_ok) exp_q.push_back(pend);
        reset        = rs;
        bus.stall    = st;
        bus.flush    = fl;
        bus.valid_in = v;
        bus.ctrl_in  = c;
        bus.rd_in    = r;
        bus.data_in  = d;
        pend_ok      = v && !st && !fl && !rs;
        pend         = '{ctrl: c, rd: r, data: d, adv: 0};
`ifdef PIPE_CHAIN_BYPASS_EN
        if (q < 0) bus.qry_rd = ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        else bus.qry_rd = 5'(q);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'($urandom), 5'($urandom), 64'($urandom), 1'b0, 1'b0, 1'b0, -1);
    endtask

    // Monitor: compare what the DUT presents against the queue, then apply the coming edge to the model.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_valid;
            exp_valid = (exp_q.size() > 0) && (exp_q[0].adv == DEPTH - 1);
            chk("valid_out", 64'(bus.valid_out), 64'(exp_valid));
            if (exp_valid) begin
                chk("ctrl_out", 64'(bus.ctrl_out), 64'(exp_q[0].ctrl));
                chk("rd_out", 64'(bus.rd_out), 64'(exp_q[0].rd));
                chk("data_out", bus.data_out, exp_q[0].data);
            end else begin
                chk("bubble_ctrl", 64'(bus.ctrl_out), 64'd0);
                chk("bubble_rd", 64'(bus.rd_out), 64'd31);
            end
            chk("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
            if (prev_reset) chk("reset_data", bus.data_out, 64'd0);
`ifdef PIPE_CHAIN_BYPASS_EN
            begin
                bit          exp_hit;
                logic [63:0] exp_fd;
                exp_hit = 1'b0;
                exp_fd  = '0;
                foreach (exp_q[i]) begin
                    if (exp_q[i].ctrl[0] && exp_q[i].rd == bus.qry_rd && bus.qry_rd != 5'd31) begin
                        exp_hit = 1'b1;
                        exp_fd  = exp_q[i].data;
                    end
                end
                chk("fwd_hit", 64'(bus.fwd_hit), 64'(exp_hit));
                chk("fwd_data", bus.fwd_data, exp_fd);
            end
`endif
            if (reset || bus.flush) begin
                exp_q.delete();
            end else if (!bus.stall) begin
                if (exp_valid) begin
                    $display("OUT rd=%0d ctrl=%h data=%h", exp_q[0].rd, exp_q[0].ctrl, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                foreach (exp_q[i]) exp_q[i].adv++;
            end
            prev_reset = reset;
        end
    end

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0; bus.valid_in = 1'b0;
        bus.ctrl_in = '0; bus.rd_in = '0; bus.data_in = '0;
`ifdef PIPE_CHAIN_BYPASS_EN
        bus.qry_rd = '0;
`endif
        drive(0, 0, 0, 0, 0, 0, 1, -1);
        drive(0, 0, 0, 0, 0, 0, 1, -1);
        mon_en = 1'b1;

        // Single valid then streaming valids: latency DEPTH, occupancy ramps 1,2,3.
        drive(1, 4'b0001, 5'd7, 64'hA5, 0, 0, 0, -1);
        drive(1, 4'b0011, 5'd8, 64'hB6, 0, 0, 0, -1);
        drive(1, 4'b0101, 5'd9, 64'hC7, 0, 0, 0, -1);
        idle(4);

        // Stall for two cycles mid-stream with the upstream holding its value.
        drive(1, 4'h1, 5'd1, 64'd1, 0, 0, 0, -1);
        drive(1, 4'h1, 5'd2, 64'd2, 0, 0, 0, -1);
        drive(1, 4'h1, 5'd3, 64'd3, 1, 0, 0, -1);
        drive(1, 4'h1, 5'd3, 64'd3, 1, 0, 0, -1);
        drive(1, 4'h1, 5'd3, 64'd3, 0, 0, 0, -1);
        idle(4);

        // Full chain, then flush together with stall.
        for (int i = 0; i < 3; i++) drive(1, 4'h1, 5'(i + 10), 64'(i + 100), 0, 0, 0, -1);
        drive(1, 4'h1, 5'd20, 64'h55, 1, 1, 0, -1);
        idle(2);

        // Bubble with garbage ctrl/rd must leave the chain scrubbed.
        drive(0, 4'hF, 5'd3, 64'h77, 0, 0, 0, -1);
        idle(3);

        // Reset while three valids are in flight, then a fresh valid.
        for (int i = 0; i < 3; i++) drive(1, 4'h3, 5'(i + 4), 64'(i + 200), 0, 0, 0, -1);
        drive(1, 4'h3, 5'd12, 64'h99, 0, 0, 1, -1);
        drive(1, 4'h1, 5'd13, 64'hD00D, 0, 0, 0, -1);
        idle(4);

        // Forwarding setup: stage2 {rd4,d9}, stage1 {rd2,d7}, stage0 {rd4,d5}.
        drive(1, 4'h1, 5'd4, 64'd9, 0, 0, 0, -1);
        drive(1, 4'h1, 5'd2, 64'd7, 0, 0, 0, -1);
        drive(1, 4'h1, 5'd4, 64'd5, 0, 0, 0, -1);
        drive(0, 4'h0, 5'd0, 64'd0, 1, 0, 0, 4);
        drive(0, 4'h0, 5'd0, 64'd0, 1, 0, 0, 31);
        idle(4);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom),
                  ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                  {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) == 0), -1);
        end
        idle(DEPTH + 3);

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
